// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count controller driving an external dual-port RAM with registered read data.
module fifo_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4,
  parameter int AF_TH     = 12,
  parameter int AE_TH     = 2
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error,
  output logic                 ram_write,
  output logic [ADDR_BITS-1:0] ram_addr_write,
  output logic [DATA_BITS-1:0] ram_data_in,
  output logic                 ram_read,
  output logic [ADDR_BITS-1:0] ram_addr_read,
  input  logic [DATA_BITS-1:0] ram_data_out
);
  localparam int CW = ADDR_BITS + 1;
  localparam int DEPTH = 1 << ADDR_BITS;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 error_q, error_d, valid_q, push_ok, pop_ok;
  assign full         = count_q == CW'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_TH);
  assign almost_empty = count_q <= CW'(AE_TH);
  // a push into a full FIFO is fine when a pop frees the same slot this cycle
  assign push_ok = reset_L & push & (~full | pop);
  assign pop_ok  = reset_L & pop & ~empty;
  assign ram_write      = push_ok;
  assign ram_read       = pop_ok;
  assign ram_addr_write = wr_ptr_q;
  assign ram_addr_read  = rd_ptr_q;
  assign ram_data_in    = data_in;
  assign data_out       = ram_data_out;
  assign valid_out      = valid_q;
  assign error          = error_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_BITS'(push_ok);
    rd_ptr_d = rd_ptr_q + ADDR_BITS'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    error_d  = error_q | (push & full & ~pop) | (pop & empty);
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      valid_q  <= pop_ok;
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed checks of fifo_ctrl against a behavioural registered-read RAM.
module tb_fifo_ctrl;
  logic       clk = 1'b0, reset_L = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] data_in = '0, data_out, ram_data_in, ram_data_out;
  logic       valid_out, full, empty, almost_full, almost_empty, error, ram_write, ram_read;
  logic [3:0] ram_addr_write, ram_addr_read;
  logic [7:0] mem [16];
  int         n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  fifo_ctrl dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .error(error),
    .ram_write(ram_write), .ram_addr_write(ram_addr_write), .ram_data_in(ram_data_in),
    .ram_read(ram_read), .ram_addr_read(ram_addr_read), .ram_data_out(ram_data_out)
  );
  always_ff @(posedge clk) begin
    if (ram_write) mem[ram_addr_write] <= ram_data_in;
    if (ram_read) ram_data_out <= mem[ram_addr_read];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [3:0] a0);
    for (int i = 0; i < 16; i++) begin
      push = 1'b1;
      data_in = 8'(i + 1);
      #1;
      check("fill_wen", ram_write, 1);
      check("fill_waddr", ram_addr_write, 32'(4'(a0 + 4'(i))));
      step();
      check("fill_af", almost_full, (i + 1) >= 12);
      check("fill_full", full, (i + 1) == 16);
      check("fill_ae", almost_empty, (i + 1) <= 2);
    end
    push = 1'b0;
  endtask
  task automatic drain(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      pop = 1'b1;
      step();
      check("drain_valid", valid_out, 1);
      check("drain_data", data_out, 32'(8'(first + 8'(i))));
    end
  endtask
  task automatic finish_drain();
    pop = 1'b0;
    step();
    check("drain_end_valid", valid_out, 0);
    check("drain_end_empty", empty, 1);
  endtask
  task automatic do_reset();
    reset_L = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    step();
    reset_L = 1'b1;
    step();
  endtask
  initial begin
    push = 1'b1;
    repeat (2) step();
    check("rst_wen_forced", ram_write, 0);
    push = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_error", error, 0);
    check("rst_valid", valid_out, 0);
    check("rst_ren", ram_read, 0);
    reset_L = 1'b1;
    step();
    fill(4'd0);
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      #1;
      check("drain_raddr", ram_addr_read, 32'(i));
      step();
      check("drain_valid", valid_out, 1);
      check("drain_data", data_out, 32'(i + 1));
    end
    finish_drain();
    fill(4'd0);
    push = 1'b1;
    pop = 1'b1;
    data_in = 8'hAA;
    step();
    push = 1'b0;
    check("pp_full", full, 1);
    check("pp_error", error, 0);
    check("pp_valid", valid_out, 1);
    check("pp_data", data_out, 8'h01);
    drain(8'h02, 15);
    step();
    check("pp_last_valid", valid_out, 1);
    check("pp_last_data", data_out, 8'hAA);
    finish_drain();
    fill(4'd1);
    push = 1'b1;
    data_in = 8'h55;
    #1;
    check("ovf_wen", ram_write, 0);
    step();
    push = 1'b0;
    check("ovf_error", error, 1);
    check("ovf_full", full, 1);
    drain(8'h01, 16);
    finish_drain();
    check("ovf_error_sticky", error, 1);
    do_reset();
    check("rst2_error", error, 0);
    push = 1'b1;
    pop = 1'b1;
    data_in = 8'h33;
    #1;
    check("epp_ren", ram_read, 0);
    check("epp_wen", ram_write, 1);
    step();
    push = 1'b0;
    check("epp_error", error, 1);
    check("epp_empty", empty, 0);
    check("epp_valid", valid_out, 0);
    step();
    check("epp_pop_valid", valid_out, 1);
    check("epp_pop_data", data_out, 8'h33);
    finish_drain();
    do_reset();
    pop = 1'b1;
    #1;
    check("udf_ren", ram_read, 0);
    step();
    pop = 1'b0;
    check("udf_valid", valid_out, 0);
    check("udf_error", error, 1);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      push = 1'b1;
      data_in = 8'(8'h80 + i);
      #1;
      check("wrap_waddr", ram_addr_write, 32'(i % 16));
      step();
      push = 1'b0;
      pop = 1'b1;
      #1;
      check("wrap_raddr", ram_addr_read, 32'(i % 16));
      step();
      pop = 1'b0;
      check("wrap_valid", valid_out, 1);
      check("wrap_data", data_out, 32'(8'h80 + i));
    end
    check("wrap_error", error, 0);
    push = 1'b1;
    data_in = 8'hC3;
    step();
    push = 1'b0;
    pop = 1'b1;
    #2;
    reset_L = 1'b0;
    #1;
    check("mrst_empty", empty, 1);
    check("mrst_ren", ram_read, 0);
    step();
    pop = 1'b0;
    check("mrst_valid", valid_out, 0);
    reset_L = 1'b1;
    step();
    check("mrst_empty_after", empty, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
